// File: rtl/clock_step_ctrl_pkg.sv
// Shared definitions for the CPU clock step controller.
// Contents: FSM state encoding and the default debounce length for a 50 MHz clk.
package clock_step_ctrl_pkg;

    // Operating modes of the clock controller.
    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // 20 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // True when a registered level has just gone from 0 to 1.
    function automatic logic rising(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/clock_step_ctrl_if.sv
// Handshake bundle between the clock controller and its surroundings.
// Signals:
//   clk_cpu_in  - slow square wave from the divider
//   btn_step    - manual step push-button (raw, bouncy)
//   sw_manual   - run/step switch (raw, bouncy), 1 = manual
//   hlt         - CPU halt line
//   cpu_tick    - one-cycle clock-enable pulse
//   cpu_clk_out - level view of the selected clock for the LED
//   mode_manual - current debounced mode
//   halted      - high once halted
// Modports: master drives the inputs of the controller, slave is the controller.
interface clock_step_ctrl_if;
    logic clk_cpu_in;
    logic btn_step;
    logic sw_manual;
    logic hlt;
    logic cpu_tick;
    logic cpu_clk_out;
    logic mode_manual;
    logic halted;

    modport master (
        output clk_cpu_in, btn_step, sw_manual, hlt,
        input  cpu_tick, cpu_clk_out, mode_manual, halted
    );

    modport slave (
        input  clk_cpu_in, btn_step, sw_manual, hlt,
        output cpu_tick, cpu_clk_out, mode_manual, halted
    );
endinterface

// File: rtl/clock_step_ctrl_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// Ports:
//   clk, reset_n - system clock, asynchronous active-low reset
//   din          - raw asynchronous input
//   dout         - registered debounced level
// The debounced level flips only after DEBOUNCE_CYCLES consecutive cycles of
// disagreement between the synchronised input and the current debounced level.
module clock_step_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             state_r;

    // Synchronise the raw input into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreement cycles; flip on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= 1'b0;
        end else if (sync2_r == state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // This is the DEBOUNCE_CYCLES-th disagreeing edge.
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ~state_r;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign dout = state_r;

endmodule

// File: rtl/clock_step_ctrl.sv
// CPU clock consumer: selects between the divider square wave (auto) and the
// debounced step button (manual), honours the sticky HLT line, and emits a
// one-cycle clock-enable pulse per selected rising edge.
// Ports:
//   clk, reset_n - 50 MHz system clock, asynchronous active-low reset
//   bus          - slave side of clock_step_ctrl_if (inputs and all outputs)
// All outputs are registered.
module clock_step_ctrl
    import clock_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    clock_step_ctrl_if.slave  bus
);

    state_t state_r;
    logic   cpu_in_r;
    logic   cpu_in_prev_r;
    logic   btn_prev_r;
    logic   btn_db_s;
    logic   sw_db_s;
    logic   cpu_rise_s;
    logic   btn_rise_s;

    clock_step_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.btn_step),
        .dout    (btn_db_s)
    );

    clock_step_ctrl_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_sw (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (bus.sw_manual),
        .dout    (sw_db_s)
    );

    // Register the divider clock and keep previous values of both sources
    // every cycle, so switching modes never sees a stale level as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_in_r      <= 1'b0;
            cpu_in_prev_r <= 1'b0;
            btn_prev_r    <= 1'b0;
        end else begin
            cpu_in_r      <= bus.clk_cpu_in;
            cpu_in_prev_r <= cpu_in_r;
            btn_prev_r    <= btn_db_s;
        end
    end

    assign cpu_rise_s = rising(cpu_in_r, cpu_in_prev_r);
    assign btn_rise_s = rising(btn_db_s, btn_prev_r);

    // Mode FSM with registered tick, LED level, mode and halt outputs.
    // Halt has priority over a mode change, which has priority over a tick;
    // an edge coinciding with either is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_AUTO;
            bus.cpu_tick    <= 1'b0;
            bus.cpu_clk_out <= 1'b0;
            bus.mode_manual <= 1'b0;
            bus.halted      <= 1'b0;
        end else begin
            case (state_r)
                ST_AUTO: begin
                    if (bus.hlt) begin
                        state_r         <= ST_HALTED;
                        bus.cpu_tick    <= 1'b0;
                        bus.cpu_clk_out <= 1'b0;
                        bus.halted      <= 1'b1;
                    end else if (sw_db_s) begin
                        state_r         <= ST_MANUAL;
                        bus.cpu_tick    <= 1'b0;
                        bus.cpu_clk_out <= btn_db_s;
                        bus.mode_manual <= 1'b1;
                    end else begin
                        bus.cpu_tick    <= cpu_rise_s;
                        bus.cpu_clk_out <= cpu_in_r;
                    end
                end
                ST_MANUAL: begin
                    if (bus.hlt) begin
                        state_r         <= ST_HALTED;
                        bus.cpu_tick    <= 1'b0;
                        bus.cpu_clk_out <= 1'b0;
                        bus.halted      <= 1'b1;
                    end else if (!sw_db_s) begin
                        state_r         <= ST_AUTO;
                        bus.cpu_tick    <= 1'b0;
                        bus.cpu_clk_out <= cpu_in_r;
                        bus.mode_manual <= 1'b0;
                    end else begin
                        bus.cpu_tick    <= btn_rise_s;
                        bus.cpu_clk_out <= btn_db_s;
                    end
                end
                ST_HALTED: begin
                    // Sticky until reset; mode_manual keeps its last value.
                    bus.cpu_tick    <= 1'b0;
                    bus.cpu_clk_out <= 1'b0;
                    bus.halted      <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: stop the CPU rather than run it.
                    state_r         <= ST_HALTED;
                    bus.cpu_tick    <= 1'b0;
                    bus.cpu_clk_out <= 1'b0;
                    bus.halted      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Self-checking bench for clock_step_ctrl with DEBOUNCE_CYCLES = 4.
// Stimulus pushes the expected cycle number of each cpu_tick into a queue;
// a monitor on the falling edge pops and compares every tick the DUT emits.
module tb_clock_step_ctrl;

    logic clk;
    logic reset_n;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];

    clock_step_ctrl_if bus_if ();

    clock_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising clk edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0b required=%0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every tick must match the oldest expected cycle.
    always @(negedge clk) begin
        if (reset_n && bus_if.cpu_tick === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tick actual=tick@%0d required=no tick", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL tick_cycle actual=%0d required=%0d", cyc, e);
                end
            end
            tests++;
            if (bus_if.cpu_clk_out !== 1'b1) begin
                fails++;
                $display("FAIL clk_out_at_tick actual=%0b required=1", bus_if.cpu_clk_out);
            end
        end
    end

    // One divider period: high 10 cycles, low 10 cycles.
    task automatic cpu_period(input bit expect_tick);
        bus_if.clk_cpu_in = 1'b1;
        if (expect_tick) exp_q.push_back(cyc + 2);
        step(10);
        bus_if.clk_cpu_in = 1'b0;
        step(10);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"},   bus_if.cpu_tick,    1'b0);
        chk({tag, "_clkout"}, bus_if.cpu_clk_out, 1'b0);
        chk({tag, "_mode"},   bus_if.mode_manual, 1'b0);
        chk({tag, "_halted"}, bus_if.halted,      1'b0);
    endtask

    initial begin
        reset_n           = 1'b0;
        bus_if.clk_cpu_in = 1'b0;
        bus_if.btn_step   = 1'b0;
        bus_if.sw_manual  = 1'b0;
        bus_if.hlt        = 1'b0;
        step(3);
        chk_all_zero("reset");
        reset_n = 1'b1;
        step(3);

        // Test 1: auto mode, three divider periods, one tick each.
        for (int i = 0; i < 3; i++) begin
            bus_if.clk_cpu_in = 1'b1;
            exp_q.push_back(cyc + 2);
            step(10);
            chk("auto_clkout_high", bus_if.cpu_clk_out, 1'b1);
            bus_if.clk_cpu_in = 1'b0;
            step(10);
            chk("auto_clkout_low", bus_if.cpu_clk_out, 1'b0);
        end

        // Test 2: enter manual, divider ignored, bouncy button gives one tick.
        bus_if.sw_manual = 1'b1;
        step(12);
        chk("manual_mode", bus_if.mode_manual, 1'b1);
        chk("manual_not_halted", bus_if.halted, 1'b0);
        cpu_period(1'b0);
        bus_if.btn_step = 1'b1;
        step(1);
        bus_if.btn_step = 1'b0;
        step(1);
        bus_if.btn_step = 1'b1;
        exp_q.push_back(cyc + 7);
        step(20);
        chk("manual_clkout_btn", bus_if.cpu_clk_out, 1'b1);
        bus_if.btn_step = 1'b0;
        step(10);
        chk("manual_clkout_release", bus_if.cpu_clk_out, 1'b0);

        // Test 3: 3-cycle glitch is filtered out.
        bus_if.btn_step = 1'b1;
        step(3);
        bus_if.btn_step = 1'b0;
        step(12);
        chk("glitch_db_state", bus_if.cpu_clk_out, 1'b0);

        // Test 5: switch to auto while both sources are high.
        bus_if.clk_cpu_in = 1'b1;
        step(3);
        bus_if.btn_step = 1'b1;
        exp_q.push_back(cyc + 7);
        step(15);
        bus_if.sw_manual = 1'b0;
        step(12);
        chk("switch_mode_auto", bus_if.mode_manual, 1'b0);
        chk("switch_clkout", bus_if.cpu_clk_out, 1'b1);
        bus_if.btn_step   = 1'b0;
        bus_if.clk_cpu_in = 1'b0;
        step(10);
        cpu_period(1'b1);

        // Test 4: halt coincident with a divider rising edge.
        bus_if.clk_cpu_in = 1'b1;
        step(1);
        bus_if.hlt = 1'b1;
        step(1);
        bus_if.hlt = 1'b0;
        chk("halt_now", bus_if.halted, 1'b1);
        step(8);
        bus_if.clk_cpu_in = 1'b0;
        step(10);
        cpu_period(1'b0);
        chk("halt_sticky", bus_if.halted, 1'b1);
        chk("halt_mode_hold", bus_if.mode_manual, 1'b0);
        chk("halt_clkout", bus_if.cpu_clk_out, 1'b0);

        // Test 6a: reset for 3 cycles while halted.
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);
        chk_all_zero("rst_halted");

        // Test 6b: reset landing in the middle of a tick.
        bus_if.clk_cpu_in = 1'b1;
        step(2);
        chk("tick_before_reset", bus_if.cpu_tick, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("tick_drop_async", bus_if.cpu_tick, 1'b0);
        bus_if.clk_cpu_in = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(3);
        chk_all_zero("rst_midtick");
        cpu_period(1'b1);
        cpu_period(1'b1);

        step(5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_ticks actual=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
